// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types and defaults for the CPU clock controller.
package cpu_clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DEFAULT_DIV   = 5;
    localparam int DEFAULT_CNT_W = 32;
    // Phase counter width: DIV is limited to 255, so eight bits always suffice.
    localparam int PH_W          = 8;

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Command/status bundle between a run-control host and cpu_clock_ctrl.
// Breakpoint signals exist only when CPU_CLOCK_BREAKPOINT_EN is defined.
interface cpu_clock_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmdRun;
    logic             cmdHalt;
    logic             cmdStep;
    logic             cpuHalt;
    logic             pcClk;
    logic             pcStrobe;
    logic             busy;
    logic [CNT_W-1:0] periodCount;
`ifdef CPU_CLOCK_BREAKPOINT_EN
    logic [31:0]      pcValue;
    logic [31:0]      bpAddr;
    logic             bpEnable;
    logic             bpHit;
`endif

    modport master (
        output cmdRun, cmdHalt, cmdStep, cpuHalt,
`ifdef CPU_CLOCK_BREAKPOINT_EN
        output pcValue, bpAddr, bpEnable,
        input  bpHit,
`endif
        input  pcClk, pcStrobe, busy, periodCount
    );

    modport slave (
        input  cmdRun, cmdHalt, cmdStep, cpuHalt,
`ifdef CPU_CLOCK_BREAKPOINT_EN
        input  pcValue, bpAddr, bpEnable,
        output bpHit,
`endif
        output pcClk, pcStrobe, busy, periodCount
    );

endinterface

// File: rtl/cpu_clock_ctrl_phase_counter.sv
// Mod-DIV phase counter with enable, synchronous clear and terminal count.
// Exposes its next value so the owner can register outputs aligned with it.
module phase_counter
    import cpu_clock_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            en_i,
    input  logic            clr_i,
    output logic [PH_W-1:0] cnt_o,
    output logic [PH_W-1:0] cntNext_o,
    output logic            tc_o
);

    logic [PH_W-1:0] cntQ;
    logic [PH_W-1:0] cntD;

    assign tc_o = (cntQ == PH_W'(DIV - 1));

    always_comb begin
        cntD = cntQ;
        if (clr_i) begin
            cntD = '0;
        end else if (en_i) begin
            cntD = tc_o ? '0 : cntQ + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign cnt_o     = cntQ;
    assign cntNext_o = cntD;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step generator for the CPU's pcClk and pcStrobe.
// Optional breakpoint stop is enabled by defining CPU_CLOCK_BREAKPOINT_EN.
module cpu_clock_ctrl
    import cpu_clock_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rstN,
    cpu_clock_ctrl_if.slave  bus
);

    state_e           stateQ, stateD;
    logic             runPendQ, runPendD;
    logic             pcClkQ, pcClkD;
    logic             pcStrobeQ, pcStrobeD;
    logic [CNT_W-1:0] countQ;
    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  phNext;
    logic             tc;
    logic             haltReq;
`ifdef CPU_CLOCK_BREAKPOINT_EN
    logic             bpHitQ, bpHitD;
`endif

    phase_counter #(.DIV(DIV)) uPhase (
        .clk       (clk),
        .rstN      (rstN),
        .en_i      (stateQ != IDLE),
        .clr_i     (stateQ == IDLE),
        .cnt_o     (ph),
        .cntNext_o (phNext),
        .tc_o      (tc)
    );

    assign haltReq = bus.cmdHalt | bus.cpuHalt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ    <= IDLE;
            runPendQ  <= 1'b0;
            pcClkQ    <= 1'b0;
            pcStrobeQ <= 1'b0;
            countQ    <= '0;
        end else begin
            stateQ    <= stateD;
            runPendQ  <= runPendD;
            pcClkQ    <= pcClkD;
            pcStrobeQ <= pcStrobeD;
            countQ    <= countQ + CNT_W'(pcStrobeD);
        end
    end

    // A period that has started always runs to its terminal count before leaving.
    always_comb begin
        stateD   = stateQ;
        runPendD = runPendQ;
        unique case (stateQ)
            IDLE: begin
                runPendD = 1'b0;
                if (!bus.cmdHalt) begin
                    if (bus.cmdRun) begin
                        stateD = RUN;
                    end else if (bus.cmdStep) begin
                        stateD = STEP;
                    end
                end
            end
            RUN: begin
                if (haltReq) begin
                    stateD = tc ? IDLE : DRAIN;
                end
            end
            STEP: begin
                if (bus.cmdRun) begin
                    runPendD = 1'b1;
                end
                if (tc) begin
                    stateD   = (runPendQ || bus.cmdRun) ? RUN : IDLE;
                    runPendD = 1'b0;
                end
            end
            DRAIN: begin
                if (tc) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
`ifdef CPU_CLOCK_BREAKPOINT_EN
        bpHitD = bpHitQ;
        if (bus.cmdRun || bus.cmdStep) begin
            bpHitD = 1'b0;
        end
        if (stateQ != IDLE && tc && bus.bpEnable && bus.pcValue == bus.bpAddr) begin
            stateD   = IDLE;
            runPendD = 1'b0;
            bpHitD   = 1'b1;
        end
`endif
    end

    // Outputs are computed from next state/phase so the registers line up with ph.
    always_comb begin
        pcClkD    = (stateD != IDLE) && (phNext < PH_W'(DIV / 2));
        pcStrobeD = (stateD != IDLE) && (phNext == PH_W'(DIV - 1));
    end

`ifdef CPU_CLOCK_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bpHitQ <= 1'b0;
        end else begin
            bpHitQ <= bpHitD;
        end
    end

    assign bus.bpHit = bpHitQ;
`endif

    assign bus.pcClk       = pcClkQ;
    assign bus.pcStrobe    = pcStrobeQ;
    assign bus.busy        = (stateQ != IDLE);
    assign bus.periodCount = countQ;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: expected periodCount values are queued
// per strobe and a negedge monitor pops and compares them.
module tb_cpu_clock_ctrl;

    localparam int DIV   = 5;
    localparam int CNT_W = 32;

    logic clk;
    logic rstN;
    int   total;
    int   bad;
    logic [CNT_W-1:0] expQ[$];

    cpu_clock_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cpu_clock_ctrl #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic run, input logic halt,
                                 input logic step, input logic cpuH);
        bus.cmdRun  = run;
        bus.cmdHalt = halt;
        bus.cmdStep = step;
        bus.cpuHalt = cpuH;
    endtask

    // Every strobe must match the next queued count; stray strobes are failures.
    always @(negedge clk) begin
        if (rstN && bus.pcStrobe === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedStrobe: got strobe with count %0d, expected none at %0t",
                         bus.periodCount, $time);
            end else begin
                checkOutput("strobeCount", bus.periodCount, expQ.pop_front());
                checkOutput("strobePcClk", {31'd0, bus.pcClk}, 32'd0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CPU_CLOCK_BREAKPOINT_EN
        bus.pcValue  = 32'd0;
        bus.bpAddr   = 32'd1;
        bus.bpEnable = 1'b0;
`endif
        tick(3);
        rstN = 1'b1;
        tick(20);
        checkOutput("idlePcClk", {31'd0, bus.pcClk}, 32'd0);
        checkOutput("idleStrobe", {31'd0, bus.pcStrobe}, 32'd0);
        checkOutput("idleBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("idleCount", bus.periodCount, 32'd0);

        // Continuous run: ten periods, then cpuHalt on the terminal cycle.
        for (int i = 1; i <= 10; i++) expQ.push_back(CNT_W'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (k == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("runPcClk", {31'd0, bus.pcClk}, {31'd0, (k % DIV) < (DIV / 2)});
        end
        checkOutput("runCount", bus.periodCount, 32'd10);
        checkOutput("runBusy", {31'd0, bus.busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cpuHaltBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("cpuHaltPcClk", {31'd0, bus.pcClk}, 32'd0);
        tick(6);
        checkOutput("cpuHaltCount", bus.periodCount, 32'd10);
        checkOutput("cpuHaltPcClkLater", {31'd0, bus.pcClk}, 32'd0);

        // Single step: busy for exactly DIV cycles.
        expQ.push_back(CNT_W'(11));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < DIV; k++) begin
            tick(1);
            if (k == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("stepBusy", {31'd0, bus.busy}, 32'd1);
        end
        tick(1);
        checkOutput("stepDoneBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("stepCount", bus.periodCount, 32'd11);

        // Halt at ph=1: the period drains, no further strobe.
        expQ.push_back(CNT_W'(12));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drainBusy", {31'd0, bus.busy}, 32'd1);
        tick(2);
        checkOutput("drainLastBusy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        checkOutput("drainIdleBusy", {31'd0, bus.busy}, 32'd0);
        tick(10);
        checkOutput("drainCount", bus.periodCount, 32'd12);

        // Halt beats run in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("prioBusy", {31'd0, bus.busy}, 32'd0);

        // Run requested during a step continues into RUN at the period end.
        expQ.push_back(CNT_W'(13));
        expQ.push_back(CNT_W'(14));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (k == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 1) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 5) checkOutput("stepToRunBusy", {31'd0, bus.busy}, 32'd1);
            if (k == 9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stepToRunIdle", {31'd0, bus.busy}, 32'd0);
        checkOutput("stepToRunCount", bus.periodCount, 32'd14);

        // Reset at ph=2 while running, then a clean restart.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        rstN = 1'b0;
        #1;
        checkOutput("rstPcClk", {31'd0, bus.pcClk}, 32'd0);
        checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rstCount", bus.periodCount, 32'd0);
        tick(1);
        rstN = 1'b1;
        tick(1);
        expQ.push_back(CNT_W'(1));
        expQ.push_back(CNT_W'(2));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (k == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("restartPcClk", {31'd0, bus.pcClk}, {31'd0, (k % DIV) < (DIV / 2)});
            if (k == 9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restartIdle", {31'd0, bus.busy}, 32'd0);
        checkOutput("restartCount", bus.periodCount, 32'd2);

        tick(5);
        checkOutput("pendingStrobes", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Generates the CPU's program-counter clock `pcClk` and a one-cycle `pcStrobe` from the single fast clock `clk`, under run/halt/single-step control.
- This is the synthesizable driver end of the pcClk/clk pair the CPU consumes. It replaces free-running bench clock generation and lets the top level (or a debug host) start, stop and step the core.
- Sits beside `ee3613cpu` at the top level.

Parameters:
- DIV, 5, number of clk cycles per pcClk period (legal range 2..255).
- CNT_W, 32, width of the retired-period counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstN  input  1  asynchronous active-low reset.
- cmdRun  input  1  level/pulse; request continuous running.
- cmdHalt  input  1  pulse; request stop at the end of the current period.
- cmdStep  input  1  pulse; request exactly one pcClk period.
- cpuHalt  input  1  halt instruction decoded by the CPU; treated as cmdHalt.
- pcClk  output  1  registered divided clock to the CPU.
- pcStrobe  output  1  one-clk pulse in the last clk cycle of each pcClk period.
- busy  output  1  high in any state other than IDLE.
- periodCount  output  CNT_W  number of completed pcClk periods.

Behaviour:
- Reset (rstN=0, async): state=IDLE, phase counter=0, pcClk=0, pcStrobe=0, busy=0, periodCount=0.
- Phase counter `ph` counts 0..DIV-1 only in RUN, STEP and DRAIN. In IDLE it is held at 0.
- pcClk is registered: pcClk=1 when ph < DIV/2 (integer division) and the state is not IDLE; otherwise 0. With DIV=5, pcClk is high for 2 and low for 3 clk cycles, period 10 clk edges.
- pcStrobe=1 exactly when ph==DIV-1 in a non-IDLE state. periodCount increments on that same cycle and wraps modulo 2^CNT_W.
- States and transitions:
  - IDLE: cmdRun → RUN; else cmdStep → STEP. ph starts at 0 on the next cycle.
  - RUN: cmdHalt|cpuHalt → DRAIN. At ph==DIV-1 with no halt, ph wraps to 0.
  - STEP: at ph==DIV-1 → IDLE. cmdRun during STEP → RUN at the period end. cmdHalt has no further effect.
  - DRAIN: continue the current period. At ph==DIV-1 → IDLE. Commands are ignored.
- Halt arriving on the same cycle as ph==DIV-1 in RUN: that period completes and the state goes directly to IDLE (no extra period).
- Priority in IDLE for simultaneous commands: cmdHalt (ignored, stay IDLE) > cmdRun > cmdStep.
- pcClk is never truncated: every period that starts completes its full DIV cycles, except when rstN asserts.
- Reset mid-period: outputs go immediately to reset values and the partial period is not counted.
- busy = (state != IDLE), registered with state.

Optional Feature:
- Macro: CPU_CLOCK_BREAKPOINT_EN.
- When defined, add these ports:
  - pcValue input 32
  - bpAddr input 32
  - bpEnable input 1
  - bpHit output 1
- At pcStrobe, if bpEnable and pcValue==bpAddr, the state goes to IDLE instead of continuing, and bpHit sets. bpHit clears on the next cmdRun/cmdStep and resets to 0.
- When undefined, these ports and that logic are absent; behaviour is exactly as above.

Decomposition:
- Package `cpu_clock_pkg`:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, STEP=2'd2, DRAIN=2'd3;
  - default DIV;
  - CNT_W.
- One natural sub-module, `phase_counter`: a mod-DIV counter with enable, synchronous clear, and a terminal-count output. The FSM and output registers stay in cpu_clock_ctrl.

Test Plan:
- Reset then idle 20 cycles → pcClk=0, pcStrobe=0, busy=0, periodCount=0.
- cmdRun pulse, DIV=5, run 50 clk cycles → 10 periods, pcClk pattern 1,1,0,0,0 repeating, pcStrobe every 5th cycle, periodCount=10.
- cmdStep from IDLE → exactly one pcStrobe, periodCount 0→1, busy high for 5 cycles, then IDLE.
- Running, cmdHalt at ph=1 → period completes (3 more cycles), no further strobe, periodCount increments by exactly 1.
- cpuHalt asserted on the ph==4 cycle → that strobe counted, state IDLE next cycle, pcClk stays 0.
- rstN low at ph=2 while running → immediate pcClk=0, busy=0, periodCount=0; cmdRun afterwards restarts cleanly from ph=0.
